// File: rtl/max6675_spi_reader.sv
// SPI master that periodically reads a 16-bit MAX6675 frame and publishes the
// decoded temperature and status bits with a single-cycle valid strobe.
module max6675_spi_reader #(
  parameter int unsigned SCK_DIV       = 8,
  parameter int unsigned CS_SETUP      = 8,
  parameter int unsigned SAMPLE_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  input  logic        miso,
  output logic        cs_n,
  output logic        sck,
  output logic [11:0] temp_raw,
  output logic [9:0]  temp_c,
  output logic [1:0]  temp_frac,
  output logic        open_tc,
  output logic        frame_err,
  output logic        valid,
  output logic        busy
);

  localparam int unsigned TMR_W   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int unsigned CNT_MAX = (SCK_DIV > CS_SETUP) ? SCK_DIV : CS_SETUP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;

  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 phase_q, phase_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [TMR_W-1:0]     timer_q;
  logic                 miso_meta, miso_sync;
  logic                 wrap, req;

  logic                 cs_n_d, sck_d, busy_d, valid_d;
  logic                 open_tc_d, frame_err_d;
  logic [11:0]          temp_raw_d;

  // miso is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // Sample timer: free-runs while enabled, including during a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (!enable) begin
      timer_q <= '0;
    end else if (timer_q == TMR_LAST) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  assign wrap = enable && (timer_q == TMR_LAST);
  assign req  = start || wrap;

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      shreg_q   <= '0;
      cs_n      <= 1'b1;
      sck       <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      temp_raw  <= '0;
      open_tc   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      shreg_q   <= shreg_d;
      cs_n      <= cs_n_d;
      sck       <= sck_d;
      busy      <= busy_d;
      valid     <= valid_d;
      temp_raw  <= temp_raw_d;
      open_tc   <= open_tc_d;
      frame_err <= frame_err_d;
    end
  end

  // Next-state: setup delay, then 16 bits of low/high SCK halves
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = BIT_W'(15);
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            shreg_d = {shreg_q[FRAME_W-2:0], miso_sync};
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == '0) begin
              state_d = DONE;
            end else begin
              bit_d = bit_q - BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; temperature only refreshes on a clean frame
  always_comb begin
    cs_n_d      = !((state_d == SETUP) || (state_d == SHIFT));
    sck_d       = (state_d == SHIFT) && phase_d;
    busy_d      = (state_d != IDLE);
    valid_d     = (state_d == DONE);
    temp_raw_d  = temp_raw;
    open_tc_d   = open_tc;
    frame_err_d = frame_err;
    if (state_d == DONE) begin
      frame_err_d = shreg_d[15] | shreg_d[1];
      open_tc_d   = shreg_d[2];
      if (!(shreg_d[15] | shreg_d[1]) && !shreg_d[2]) begin
        temp_raw_d = shreg_d[14:3];
      end
    end
  end

  assign temp_c    = temp_raw[11:2];
  assign temp_frac = temp_raw[1:0];

endmodule

// File: tb/tb_max6675_spi_reader.sv
// Scoreboard bench: two readers (default and SCK_DIV=4) served by MAX6675 models.
`timescale 1ns/1ps
module tb_max6675_spi_reader;

  localparam int CLK_NS = 10;

  typedef struct packed {
    logic [11:0] raw;
    logic        open;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic enable_a = 1'b0, start_a = 1'b0, miso_a;
  logic cs_n_a, sck_a, open_tc_a, frame_err_a, valid_a, busy_a;
  logic [11:0] temp_raw_a;
  logic [9:0]  temp_c_a;
  logic [1:0]  temp_frac_a;

  logic enable_b = 1'b0, start_b = 1'b0, miso_b;
  logic cs_n_b, sck_b, open_tc_b, frame_err_b, valid_b, busy_b;
  logic [11:0] temp_raw_b;
  logic [9:0]  temp_c_b;
  logic [1:0]  temp_frac_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] serve_a[$], serve_b[$];
  exp_t        exp_q_a[$], exp_q_b[$];
  logic [11:0] model_raw_a = '0, model_raw_b = '0;

  logic [15:0] cur_a = '0, cur_b = '0;
  int          idx_a = 0, idx_b = 0;
  logic        active_a = 1'b0, active_b = 1'b0;
  int          rises_a = 0, rises_b = 0;
  time         t1_a = 0, t2_a = 0, t1_b = 0, t2_b = 0;
  int          nvalid_a = 0, nvalid_b = 0;
  logic        prev_valid_a = 1'b0, prev_valid_b = 1'b0;

  always #(CLK_NS/2) clk = ~clk;

  max6675_spi_reader #(.SCK_DIV(8), .CS_SETUP(8), .SAMPLE_CYCLES(1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .start(start_a), .miso(miso_a),
    .cs_n(cs_n_a), .sck(sck_a), .temp_raw(temp_raw_a), .temp_c(temp_c_a),
    .temp_frac(temp_frac_a), .open_tc(open_tc_a), .frame_err(frame_err_a),
    .valid(valid_a), .busy(busy_a)
  );

  max6675_spi_reader #(.SCK_DIV(4), .CS_SETUP(4), .SAMPLE_CYCLES(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .start(start_b), .miso(miso_b),
    .cs_n(cs_n_b), .sck(sck_b), .temp_raw(temp_raw_b), .temp_c(temp_c_b),
    .temp_frac(temp_frac_b), .open_tc(open_tc_b), .frame_err(frame_err_b),
    .valid(valid_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Queue a frame for the device model and the result the reader should publish
  task automatic push_frame(input int which, input logic [15:0] f);
    exp_t e;
    e.err  = f[15] | f[1];
    e.open = f[2];
    if (which == 0) begin
      if (!e.err && !e.open) model_raw_a = f[14:3];
      e.raw = model_raw_a;
      serve_a.push_back(f);
      exp_q_a.push_back(e);
    end else begin
      if (!e.err && !e.open) model_raw_b = f[14:3];
      e.raw = model_raw_b;
      serve_b.push_back(f);
      exp_q_b.push_back(e);
    end
  endtask

  // MAX6675 model: D15 appears at cs_n fall, next bit after each sck fall
  assign miso_a = (cs_n_a === 1'b0 && active_a) ? cur_a[idx_a] : 1'b0;
  assign miso_b = (cs_n_b === 1'b0 && active_b) ? cur_b[idx_b] : 1'b0;

  always @(negedge cs_n_a or posedge cs_n_a or negedge sck_a) begin
    if (cs_n_a !== 1'b0) begin
      active_a <= 1'b0;
    end else if (!active_a) begin
      active_a <= 1'b1;
      idx_a    <= 15;
      if (serve_a.size() > 0) cur_a <= serve_a.pop_front();
      else cur_a <= 16'h0000;
    end else if (idx_a > 0) begin
      idx_a <= idx_a - 1;
    end
  end

  always @(negedge cs_n_b or posedge cs_n_b or negedge sck_b) begin
    if (cs_n_b !== 1'b0) begin
      active_b <= 1'b0;
    end else if (!active_b) begin
      active_b <= 1'b1;
      idx_b    <= 15;
      if (serve_b.size() > 0) cur_b <= serve_b.pop_front();
      else cur_b <= 16'h0000;
    end else if (idx_b > 0) begin
      idx_b <= idx_b - 1;
    end
  end

  always @(negedge cs_n_a or posedge sck_a) begin
    if (sck_a === 1'b1) begin
      rises_a <= rises_a + 1;
      if (rises_a == 0) t1_a <= $time;
      if (rises_a == 1) t2_a <= $time;
    end else begin
      rises_a <= 0;
    end
  end

  always @(negedge cs_n_b or posedge sck_b) begin
    if (sck_b === 1'b1) begin
      rises_b <= rises_b + 1;
      if (rises_b == 0) t1_b <= $time;
      if (rises_b == 1) t2_b <= $time;
    end else begin
      rises_b <= 0;
    end
  end

  // Scoreboard pop on each valid strobe
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a) begin
        check_eq("a_valid_gap", int'(prev_valid_a), 0);
        check_eq("a_busy_at_valid", int'(busy_a), 1);
        check_eq("a_cs_at_valid", int'(cs_n_a), 1);
        if (exp_q_a.size() == 0) begin
          check_eq("a_unexpected_valid", 1, 0);
        end else begin
          check_eq("a_temp_raw", int'(temp_raw_a), int'(exp_q_a[0].raw));
          check_eq("a_temp_c", int'(temp_c_a), int'(exp_q_a[0].raw) / 4);
          check_eq("a_temp_frac", int'(temp_frac_a), int'(exp_q_a[0].raw) % 4);
          check_eq("a_open_tc", int'(open_tc_a), int'(exp_q_a[0].open));
          check_eq("a_frame_err", int'(frame_err_a), int'(exp_q_a[0].err));
          void'(exp_q_a.pop_front());
        end
        nvalid_a <= nvalid_a + 1;
      end
      if (valid_b) begin
        check_eq("b_valid_gap", int'(prev_valid_b), 0);
        if (exp_q_b.size() == 0) begin
          check_eq("b_unexpected_valid", 1, 0);
        end else begin
          check_eq("b_temp_raw", int'(temp_raw_b), int'(exp_q_b[0].raw));
          check_eq("b_temp_c", int'(temp_c_b), int'(exp_q_b[0].raw) / 4);
          check_eq("b_temp_frac", int'(temp_frac_b), int'(exp_q_b[0].raw) % 4);
          check_eq("b_open_tc", int'(open_tc_b), int'(exp_q_b[0].open));
          check_eq("b_frame_err", int'(frame_err_b), int'(exp_q_b[0].err));
          void'(exp_q_b.pop_front());
        end
        nvalid_b <= nvalid_b + 1;
      end
    end
    prev_valid_a <= valid_a;
    prev_valid_b <= valid_b;
  end

  task automatic wait_valid(input int which, input int target, input int bound, input string tag);
    int n = 0;
    while (((which == 0) ? nvalid_a : nvalid_b) < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq(tag, (which == 0) ? nvalid_a : nvalid_b, target);
  endtask

  task automatic wait_cs_fall(input int which, input int bound, input string tag, output int n);
    n = 0;
    while (((which == 0) ? cs_n_a : cs_n_b) !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) check_eq(tag, 0, 1);
  endtask

  task automatic count_cs_low(input int which, output int low);
    low = 0;
    do begin
      low++;
      @(negedge clk);
    end while (((which == 0) ? cs_n_a : cs_n_b) === 1'b0 && low < 2000);
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    if (which == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int low;
    logic [15:0] b_frames [3];
    b_frames[0] = 16'h2AA8;
    b_frames[1] = 16'h5550;
    b_frames[2] = 16'h7FF8;

    repeat (4) @(negedge clk);
    check_eq("rst_cs_n", int'(cs_n_a), 1);
    check_eq("rst_sck", int'(sck_a), 0);
    check_eq("rst_temp_raw", int'(temp_raw_a), 0);
    check_eq("rst_temp_c", int'(temp_c_a), 0);
    check_eq("rst_temp_frac", int'(temp_frac_a), 0);
    check_eq("rst_open_tc", int'(open_tc_a), 0);
    check_eq("rst_frame_err", int'(frame_err_a), 0);
    check_eq("rst_valid", int'(valid_a), 0);
    check_eq("rst_busy", int'(busy_a), 0);
    check_eq("rst_cs_n_b", int'(cs_n_b), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Periodic reads: good, good, open, error, good
    push_frame(0, 16'h0C80);
    push_frame(0, 16'h00C8);
    push_frame(0, 16'h0004);
    push_frame(0, 16'h8000);
    push_frame(0, 16'h0C80);
    enable_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs_n_a !== 1'b0 && n < 3000);
    check_eq("a_first_cs_fall", n, 1000);
    count_cs_low(0, low);
    check_eq("a_cs_low_cycles", low, 264);
    check_eq("a_sck_rises", rises_a, 16);
    check_eq("a_sck_period", int'((t2_a - t1_a) / CLK_NS), 16);
    wait_valid(0, 5, 6000, "a_periodic_frames");
    enable_a = 1'b0;
    repeat (2500) @(negedge clk);
    check_eq("a_no_auto_after_disable", nvalid_a, 5);

    // Manual start; a second start mid-frame is dropped
    push_frame(0, 16'h0640);
    pulse_start(0);
    repeat (100) @(negedge clk);
    check_eq("a_busy_mid_frame", int'(busy_a), 1);
    pulse_start(0);
    wait_valid(0, 6, 1000, "a_start_frame");
    repeat (600) @(negedge clk);
    check_eq("a_single_start_frame", nvalid_a, 6);
    check_eq("a_serve_drained", serve_a.size(), 0);
    check_eq("a_busy_idle", int'(busy_a), 0);

    // start in the same cycle as a timer wrap; enable drops mid-frame
    push_frame(0, 16'h0C88);
    enable_a = 1'b1;
    repeat (999) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("a_wrap_start_cs", int'(cs_n_a), 0);
    enable_a = 1'b0;
    wait_valid(0, 7, 1000, "a_wrap_start_frame");
    repeat (600) @(negedge clk);
    check_eq("a_wrap_start_single", nvalid_a, 7);
    check_eq("a_wrap_serve_drained", serve_a.size(), 0);

    // Asynchronous reset at the 8th sck rise
    serve_a.push_back(16'h1234);
    pulse_start(0);
    wait_cs_fall(0, 100, "a_rst_cs_fall_timeout", n);
    n = 0;
    while (rises_a < 8 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("a_rst_at_rise8", rises_a, 8);
    rst_n = 1'b0;
    #1;
    check_eq("a_midrst_cs_n", int'(cs_n_a), 1);
    check_eq("a_midrst_sck", int'(sck_a), 0);
    check_eq("a_midrst_busy", int'(busy_a), 0);
    check_eq("a_midrst_valid", int'(valid_a), 0);
    check_eq("a_midrst_temp_raw", int'(temp_raw_a), 0);
    check_eq("a_midrst_temp_c", int'(temp_c_a), 0);
    check_eq("a_midrst_open_tc", int'(open_tc_a), 0);
    check_eq("a_midrst_frame_err", int'(frame_err_a), 0);
    model_raw_a = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_frame(0, 16'h0C80);
    pulse_start(0);
    wait_valid(0, 8, 1000, "a_after_reset_frame");

    // Fast SCK: alternating patterns expose any bit slip
    for (int i = 0; i < 3; i++) begin
      push_frame(1, b_frames[i]);
      pulse_start(1);
      wait_cs_fall(1, 100, "b_cs_fall_timeout", n);
      count_cs_low(1, low);
      check_eq("b_cs_low_cycles", low, 132);
      check_eq("b_sck_rises", rises_b, 16);
      check_eq("b_sck_period", int'((t2_b - t1_b) / CLK_NS), 8);
      wait_valid(1, i + 1, 500, "b_frame");
      repeat (20) @(negedge clk);
    end
    check_eq("b_exp_drained", exp_q_b.size(), 0);
    check_eq("a_exp_drained", exp_q_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
